// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA pixel path.
// Free-running h/v counters on the PLL pixel clock. The decode of the
// current counter values is registered, so every output is aligned and
// describes the counter value of the previous clock. The raster is held at
// its idle/reset state until the resynchronised PLL lock is high.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CNT_W      = 10
) (
    input  logic             vgaClk,
    input  logic             reset_n,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter-width copies of the timing boundaries
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_S_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_E_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_S_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_E_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);

    // Active levels of the sync pulses; the idle level is the complement
    localparam logic HS_ACT = (H_SYNC_POL != 0);
    localparam logic VS_ACT = (V_SYNC_POL != 0);

    // Lock synchroniser
    logic lock_meta_q;
    logic locked_s_q;

    // Raster counters
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    // Registered outputs
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    // Combinational decode of the current counters
    logic             h_act, v_act;
    logic             h_last, v_last;
    logic             hs_win, vs_win;
    logic             de_dec, ls_dec, fs_dec;
    logic [CNT_W-1:0] x_dec, y_dec;

    // Two-flop resynchroniser for the asynchronous PLL lock
    always_ff @(posedge vgaClk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            locked_s_q  <= lock_meta_q;
        end
    end

    // Decode position-dependent timing signals from h_cnt/v_cnt
    always_comb begin
        h_act  = (h_cnt_q < H_ACT_C);
        v_act  = (v_cnt_q < V_ACT_C);
        h_last = (h_cnt_q == H_LAST_C);
        v_last = (v_cnt_q == V_LAST_C);
        hs_win = (h_cnt_q >= H_SYNC_S_C) && (h_cnt_q <= H_SYNC_E_C);
        vs_win = (v_cnt_q >= V_SYNC_S_C) && (v_cnt_q <= V_SYNC_E_C);
        de_dec = h_act && v_act;
        ls_dec = (h_cnt_q == '0) && v_act;
        fs_dec = (h_cnt_q == '0) && (v_cnt_q == '0);
        x_dec  = de_dec ? h_cnt_q : '0;
        y_dec  = v_act ? v_cnt_q : '0;
    end

    // Next-state: advance the raster while locked, otherwise park at idle
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = ~HS_ACT;
        vsync_d       = ~VS_ACT;
        de_d          = 1'b0;
        x_d           = '0;
        y_d           = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (!locked_s_q) begin
            // Parking the counters at zero makes every relock start a fresh frame
            h_cnt_d     = '0;
            v_cnt_d     = '0;
            frame_cnt_d = '0;
        end else begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end

            hsync_d       = hs_win ? HS_ACT : ~HS_ACT;
            vsync_d       = vs_win ? VS_ACT : ~VS_ACT;
            de_d          = de_dec;
            x_d           = x_dec;
            y_d           = y_dec;
            line_start_d  = ls_dec;
            frame_start_d = fs_dec;
            if (fs_dec) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // Counter and output registers
    always_ff @(posedge vgaClk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HS_ACT;
            vsync_q       <= ~VS_ACT;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
